stream_mux: RTL and testbench

Parametrised N-channel, WIDTH-bit streaming multiplexer that succeeds the combinational 2:1 bus muxes in the datapath. It adds:

- registered output;
- valid/ready handshaking per channel;
- packet locking on a `last` flag;
- a runtime-selectable mode, either fixed select or round-robin arbitration.

It sits between multiple producers (register file ports, ALU result, memory read path) and a single consumer bus.

---
 rtl/stream_mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/stream_mux.sv | 128 ++++++++++++
 tb/tb_stream_mux.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared mode constants and lock-FSM state type for the stream multiplexer.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first requester above ptr_i wins, wrapping modulo N.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [SEL_W-1:0] idx_o,
    output logic             any_o
);

    int         c_int;
    logic [SEL_W-1:0] c;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        c_int = 0;
        c     = '0;
        for (int k = 1; k <= N; k++) begin
            c_int = (int'(ptr_i) + k) % N;
            c     = SEL_W'(c_int);
            if (!any_o && req_i[c]) begin
                any_o    = 1'b1;
                idx_o    = c;
                gnt_o[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N-channel valid/ready stream mux with registered output, packet locking
// and runtime fixed/round-robin channel selection.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 16,
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [SEL_W-1:0]   out_chan,
    input  logic               out_ready
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] lock_chan_q, lock_chan_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;

    logic [N-1:0]     arb_gnt;
    logic [SEL_W-1:0] arb_idx;
    logic             arb_any;

    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             can_load;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;

    rr_arbiter #(
        .N(N)
    ) u_arb (
        .req_i(in_valid),
        .ptr_i(rr_ptr_q),
        .gnt_o(arb_gnt),
        .idx_o(arb_idx),
        .any_o(arb_any)
    );

    // A held lock overrides both mode and sel until the packet's last beat.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        if (state_q == LOCKED) begin
            gnt_idx = lock_chan_q;
            gnt_any = 1'b1;
        end else if (mode == MODE_RR) begin
            gnt_idx = arb_idx;
            gnt_any = arb_any;
        end else if (int'(sel) < N) begin
            gnt_idx = sel;
            gnt_any = 1'b1;
        end
    end

    assign can_load = rst_n & enable & gnt_any & (~out_valid_q | out_ready);
    assign in_ready = can_load ? (N'(1) << gnt_idx) : '0;
    assign xfer     = |(in_valid & in_ready);
    assign sel_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
    assign sel_last = in_last[gnt_idx];

    always_comb begin
        state_d     = state_q;
        lock_chan_d = lock_chan_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_chan_d  = out_chan_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_chan_d  = gnt_idx;
            rr_ptr_d    = gnt_idx;
            if (sel_last) begin
                state_d = UNLOCKED;
            end else begin
                state_d     = LOCKED;
                lock_chan_d = gnt_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= UNLOCKED;
            lock_chan_q <= '0;
            rr_ptr_q    <= SEL_W'(N - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_chan_q  <= '0;
        end else begin
            state_q     <= state_d;
            lock_chan_q <= lock_chan_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux.sv
// Self-checking bench for stream_mux: directed scenarios plus a randomized run
// against a behavioural model of the channel-selection rules.
module tb_stream_mux;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [SW-1:0]  out_chan;
    logic           out_ready;

    // Second instance with N=3 so that a sel value >= N is reachable.
    logic           b_enable;
    logic           b_mode;
    logic [1:0]     b_sel;
    logic [2:0]     b_in_valid;
    logic [23:0]    b_in_data;
    logic [2:0]     b_in_last;
    logic [2:0]     b_in_ready;
    logic           b_out_valid;
    logic [7:0]     b_out_data;
    logic           b_out_last;
    logic [1:0]     b_out_chan;
    logic           b_out_ready;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] obs_ready, exp_ready;

    // Reference model state
    logic         m_ov;
    logic [W-1:0] m_data;
    logic         m_last;
    int           m_chan;
    logic         m_locked;
    int           m_lock;
    int           m_ptr;

    always #5 clk = ~clk;

    stream_mux #(.N(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_chan(out_chan), .out_ready(out_ready)
    );

    stream_mux #(.N(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(b_enable), .mode(b_mode),
        .sel(b_sel), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_last(b_in_last), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data),
        .out_last(b_out_last), .out_chan(b_out_chan),
        .out_ready(b_out_ready)
    );

    function automatic int model_grant();
        if (m_locked) return m_lock;
        if (mode) begin
            for (int k = 1; k <= N; k++) begin
                if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
            end
            return -1;
        end
        if (int'(sel) < N) return int'(sel);
        return -1;
    endfunction

    task automatic model_reset();
        m_ov = 1'b0; m_data = '0; m_last = 1'b0; m_chan = 0;
        m_locked = 1'b0; m_lock = 0; m_ptr = N - 1;
    endtask

    // One clock: sample in_ready at the negedge, advance the model at the edge.
    task automatic tick();
        int g;
        logic [N-1:0] rdy;
        @(negedge clk);
        g = model_grant();
        rdy = '0;
        if (rst_n && enable && g >= 0 && (!m_ov || out_ready)) rdy[g] = 1'b1;
        exp_ready = rdy;
        obs_ready = in_ready;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (g >= 0 && rdy[g] && in_valid[g]) begin
            m_ov = 1'b1;
            m_data = in_data[g*W +: W];
            m_last = in_last[g];
            m_chan = g;
            m_ptr = g;
            m_locked = !in_last[g];
            m_lock = g;
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        enable = 1'b1; mode = 1'b0; sel = '0;
        in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        in_valid = '1;
        in_last = '1;
        in_data = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs_ready !== 4'b0000) begin
                bad++;
                $display("FAIL reset_in_ready got=%b want=0000", obs_ready);
            end
        end
        total++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_chan !== 2'd0) begin
            bad++;
            $display("FAIL reset_out got v=%b d=%h c=%0d want v=0 d=0000 c=0",
                     out_valid, out_data, out_chan);
        end
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_fixed();
        idle_inputs();
        sel = 2'd2;
        in_valid = 4'b0100;
        in_last = 4'b0100;
        in_data[2*W +: W] = 16'hBEEF;
        tick();
        total++;
        if (obs_ready !== 4'b0100) begin
            bad++;
            $display("FAIL fixed_in_ready got=%b want=0100", obs_ready);
        end
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_chan !== 2'd2) begin
            bad++;
            $display("FAIL fixed_out got v=%b d=%h c=%0d want v=1 d=beef c=2",
                     out_valid, out_data, out_chan);
        end
        in_valid = '0;
        tick();
    endtask

    task automatic test_sel_out_of_range();
        b_enable = 1'b1; b_mode = 1'b0; b_sel = 2'd3; b_out_ready = 1'b1;
        b_in_valid = 3'b111; b_in_last = 3'b111; b_in_data = 24'hA5C33C;
        @(negedge clk);
        total++;
        if (b_in_ready !== 3'b000) begin
            bad++;
            $display("FAIL sel_ge_n_ready got=%b want=000", b_in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (b_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL sel_ge_n_valid got=%b want=0", b_out_valid);
        end
        b_sel = 2'd2;
        @(negedge clk);
        total++;
        if (b_in_ready !== 3'b100) begin
            bad++;
            $display("FAIL sel_2_of_3_ready got=%b want=100", b_in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (b_out_valid !== 1'b1 || b_out_data !== 8'hA5 || b_out_chan !== 2'd2) begin
            bad++;
            $display("FAIL sel_2_of_3_out got v=%b d=%h c=%0d want v=1 d=a5 c=2",
                     b_out_valid, b_out_data, b_out_chan);
        end
        b_in_valid = '0;
    endtask

    task automatic test_round_robin();
        int want [5] = '{0, 1, 2, 3, 0};
        idle_inputs();
        do_reset();
        mode = 1'b1;
        in_valid = '1;
        in_last = '1;
        for (int i = 0; i < 5; i++) begin
            in_data = {$urandom, $urandom};
            tick();
            total++;
            if (out_valid !== 1'b1 || int'(out_chan) != want[i]
                || out_data !== m_data) begin
                bad++;
                $display("FAIL rr_seq beat%0d got c=%0d d=%h want c=%0d d=%h",
                         i, out_chan, out_data, want[i], m_data);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_packet_lock();
        int want [4] = '{1, 1, 1, 2};
        idle_inputs();
        do_reset();
        mode = 1'b1;
        in_valid = 4'b0001;
        in_last = 4'b1111;
        tick();
        in_valid = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            in_last = (i == 2) ? 4'b1111 : 4'b1101;
            in_data = {$urandom, $urandom};
            tick();
            total++;
            if (int'(out_chan) != want[i] || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL lock_seq beat%0d got c=%0d v=%b want c=%0d v=1",
                         i, out_chan, out_valid, want[i]);
            end
        end
        total++;
        if (out_data !== m_data || out_last !== 1'b1) begin
            bad++;
            $display("FAIL lock_after got d=%h l=%b want d=%h l=1",
                     out_data, out_last, m_data);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_pressure();
        idle_inputs();
        do_reset();
        in_valid = 4'b0001;
        in_last = 4'b0001;
        in_data[0 +: W] = 16'hAAAA;
        tick();
        out_ready = 1'b0;
        in_data[0 +: W] = 16'hBBBB;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs_ready !== 4'b0000 || out_data !== 16'hAAAA
                || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold cyc%0d got r=%b d=%h v=%b want r=0000 d=aaaa v=1",
                         i, obs_ready, out_data, out_valid);
            end
        end
        out_ready = 1'b1;
        in_data[0 +: W] = 16'hCCCC;
        tick();
        total++;
        if (obs_ready !== 4'b0001 || out_data !== 16'hCCCC
            || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got r=%b d=%h v=%b want r=0001 d=cccc v=1",
                     obs_ready, out_data, out_valid);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_enable_lock();
        idle_inputs();
        do_reset();
        sel = 2'd1;
        in_valid = 4'b0010;
        in_last = 4'b0000;
        in_data = {16'h3003, 16'h2002, 16'h1001, 16'h0000};
        tick();
        enable = 1'b0;
        in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs_ready !== 4'b0000) begin
                bad++;
                $display("FAIL en_off_ready cyc%0d got=%b want=0000", i, obs_ready);
            end
        end
        sel = 2'd3;
        enable = 1'b1;
        tick();
        total++;
        if (obs_ready !== 4'b0010 || out_chan !== 2'd1) begin
            bad++;
            $display("FAIL en_resume_b2 got r=%b c=%0d want r=0010 c=1",
                     obs_ready, out_chan);
        end
        in_last = 4'b1010;
        tick();
        total++;
        if (out_chan !== 2'd1 || out_last !== 1'b1) begin
            bad++;
            $display("FAIL en_resume_b3 got c=%0d l=%b want c=1 l=1",
                     out_chan, out_last);
        end
        tick();
        total++;
        if (out_chan !== 2'd3 || out_data !== 16'h3003) begin
            bad++;
            $display("FAIL en_sel_after got c=%0d d=%h want c=3 d=3003",
                     out_chan, out_data);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        idle_inputs();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            enable    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0) sel = SW'($urandom_range(0, N - 1));
            in_valid  = N'($urandom);
            in_last   = N'($urandom) | N'($urandom);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            total++;
            if (obs_ready !== exp_ready || out_valid !== m_ov
                || out_data !== m_data || out_last !== m_last
                || int'(out_chan) != m_chan) begin
                bad++;
                $display("FAIL rand cyc%0d got r=%b v=%b d=%h l=%b c=%0d want r=%b v=%b d=%h l=%b c=%0d",
                         i, obs_ready, out_valid, out_data, out_last, out_chan,
                         exp_ready, m_ov, m_data, m_last, m_chan);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        b_enable = 1'b0; b_mode = 1'b0; b_sel = '0; b_out_ready = 1'b1;
        b_in_valid = '0; b_in_last = '0; b_in_data = '0;
        rst_n = 1'b0;
        #1;
        test_reset();
        test_fixed();
        test_sel_out_of_range();
        test_round_robin();
        test_packet_lock();
        test_back_pressure();
        test_enable_lock();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
